// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch, load/store and memory-side signals
// of the shared memory port, with requester and arbiter views.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_kill;
  logic              i_gnt;
  logic              i_rvalid;
  logic [DATA_W-1:0] i_rdata;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [3:0]        d_wstrb;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;
  logic              m_en;
  logic [3:0]        m_we;
  logic [ADDR_W-3:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic [DATA_W-1:0] m_rdata;

  modport master (
    output i_req, i_addr, i_kill,
    output d_req, d_we, d_addr, d_wdata, d_wstrb,
    output m_rdata,
    input  i_gnt, i_rvalid, i_rdata,
    input  d_gnt, d_rvalid, d_rdata,
    input  m_en, m_we, m_addr, m_wdata
  );

  modport slave (
    input  i_req, i_addr, i_kill,
    input  d_req, d_we, d_addr, d_wdata, d_wstrb,
    input  m_rdata,
    output i_gnt, i_rvalid, i_rdata,
    output d_gnt, d_rvalid, d_rdata,
    output m_en, m_we, m_addr, m_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and load/store.
// Define MEM_ARB_STARVE_GUARD_EN to build the fetch starvation guard.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MEM_LATENCY  = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  mem_port_arbiter_if.slave bus
);
  localparam logic SRC_FETCH = 1'b0;
  localparam logic SRC_DATA  = 1'b1;
  localparam int   L         = MEM_LATENCY;

  typedef enum logic {DATA_PRI, FETCH_PRI} pri_e;

  pri_e         state_q, state_d;
  logic         i_gnt, d_gnt, fetch_ok;
  logic [L-1:0] tv_q, tv_d;
  logic [L-1:0] ts_q, ts_d;
  logic [L-1:0] live;
  logic         unused_lo;

  assign unused_lo = ^{bus.i_addr[1:0], bus.d_addr[1:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= DATA_PRI;
    else     state_q <= state_d;
  end

`ifdef MEM_ARB_STARVE_GUARD_EN
  logic [2:0] cnt_q, cnt_d;
  logic       starve;

  assign starve = bus.i_req & ~i_gnt & ~bus.i_kill;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (!bus.i_req || i_gnt) cnt_d = '0;
    else if (starve)         cnt_d = cnt_q + 3'd1;
  end

  always_comb begin
    state_d = state_q;
    if (i_gnt)
      state_d = DATA_PRI;
    else if (starve && cnt_d == 3'(STARVE_LIMIT))
      state_d = FETCH_PRI;
  end
`else
  logic unused_cfg;

  assign unused_cfg = |STARVE_LIMIT;

  always_comb state_d = DATA_PRI;
`endif

  // a redirect blocks new fetches in the same cycle
  assign fetch_ok = bus.i_req & ~bus.i_kill;

  always_comb begin
    i_gnt = 1'b0;
    d_gnt = 1'b0;
    unique case (state_q)
      FETCH_PRI: begin
        i_gnt = fetch_ok;
        d_gnt = bus.d_req & ~fetch_ok;
      end
      default: begin
        d_gnt = bus.d_req;
        i_gnt = fetch_ok & ~bus.d_req;
      end
    endcase
    if (rst) begin
      i_gnt = 1'b0;
      d_gnt = 1'b0;
    end
  end

  assign live = tv_q & ~({L{bus.i_kill}} & ~ts_q);

  always_comb begin
    tv_d    = '0;
    ts_d    = '0;
    tv_d[0] = i_gnt | (d_gnt & ~bus.d_we);
    ts_d[0] = d_gnt ? SRC_DATA : SRC_FETCH;
    for (int k = 1; k < L; k++) begin
      tv_d[k] = live[k-1];
      ts_d[k] = ts_q[k-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tv_q <= '0;
      ts_q <= '0;
    end else begin
      tv_q <= tv_d;
      ts_q <= ts_d;
    end
  end

  assign bus.i_gnt    = i_gnt;
  assign bus.d_gnt    = d_gnt;
  assign bus.i_rvalid = live[L-1] & ~ts_q[L-1] & ~rst;
  assign bus.d_rvalid = live[L-1] & ts_q[L-1] & ~rst;
  assign bus.i_rdata  = bus.m_rdata;
  assign bus.d_rdata  = bus.m_rdata;

  assign bus.m_en    = i_gnt | d_gnt;
  assign bus.m_addr  = i_gnt ? bus.i_addr[ADDR_W-1:2]
                             : bus.d_addr[ADDR_W-1:2];
  assign bus.m_we    = (d_gnt & bus.d_we) ? bus.d_wstrb : 4'b0;
  assign bus.m_wdata = bus.d_wdata;
endmodule
